// File: rtl/window3x3_gen.sv
// Raster-to-window stage: turns a one-pixel-per-cycle 8-bit stream into registered
// 3x3 neighbourhoods using two line buffers and a 3x3 shift window.
module window3x3_gen #(
  parameter int IMG_W = 640
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [7:0]            in_data,
  output logic                  out_valid,
  output logic [2:0][2:0][7:0]  out_win
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);

  logic [CW-1:0]         r_col;
  logic [1:0]            r_row;
  logic [7:0]            r_lineBuf1 [IMG_W];
  logic [7:0]            r_lineBuf2 [IMG_W];
  logic [2:0][2:0][7:0]  r_win;

  logic [CW-1:0]         w_col;
  logic [1:0]            w_row;
  logic [7:0]            w_lb1;
  logic [7:0]            w_lb2;
  logic                  w_emit;
  logic [2:0][2:0][7:0]  w_nextWin;

  // A start-of-frame pixel is forced to position (0,0), abandoning any partial frame.
  assign w_col  = in_sof ? '0 : r_col;
  assign w_row  = in_sof ? 2'd0 : r_row;
  assign w_lb1  = r_lineBuf1[w_col];
  assign w_lb2  = r_lineBuf2[w_col];
  assign w_emit = (w_row == 2'd2) && (w_col >= CW'(2));

  always_comb begin
    w_nextWin = r_win;
    for (int r = 0; r < 3; r++) begin
      w_nextWin[r][0] = r_win[r][1];
      w_nextWin[r][1] = r_win[r][2];
    end
    w_nextWin[0][2] = w_lb2;
    w_nextWin[1][2] = w_lb1;
    w_nextWin[2][2] = in_data;
  end

  // Line buffers are plain memories; stale contents are masked by the row counter.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_lineBuf2[w_col] <= w_lb1;
      r_lineBuf1[w_col] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_row     <= '0;
      r_win     <= '0;
      out_valid <= 1'b0;
      out_win   <= '0;
    end else begin
      out_valid <= in_valid && w_emit;
      if (in_valid) begin
        r_win <= w_nextWin;
        if (w_emit) begin
          out_win <= w_nextWin;
        end
        if (w_col == LAST_COL) begin
          r_col <= '0;
          r_row <= (w_row == 2'd2) ? w_row : w_row + 2'd1;
        end else begin
          r_col <= w_col + CW'(1);
          r_row <= w_row;
        end
      end
    end
  end

endmodule
